// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: 4-digit common-anode seven-segment scanner with dead-time blanking,
// PWM brightness and a frame-synchronous shadow register. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  brightness,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);

  localparam int SLOT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ON   = SLOT_W'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      4'hF:    code = 7'b0001110;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  function automatic logic lz_blank(input logic [15:0] value, input logic [1:0] idx);
    logic blank;
    case (idx)
      2'd3:    blank = (value[15:12] == 4'h0);
      2'd2:    blank = (value[15:8] == 8'h00);
      2'd1:    blank = (value[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction
`endif

  logic [SLOT_W-1:0] slot_cnt_r;
  logic [1:0]        digit_r;
  logic [3:0]        pwm_cnt_r;
  state_t            state_r;
  logic [15:0]       active_data_r;
  logic [3:0]        active_dp_r;
  logic [15:0]       pend_data_r;
  logic [3:0]        pend_dp_r;
  logic              pending_r;
  logic [3:0]        anode_r;
  logic [6:0]        seg_r;
  logic              dp_r;
  logic              frame_done_r;

  logic              slot_wrap_s;
  logic              frame_end_s;
  logic [SLOT_W-1:0] next_slot_s;
  logic              pwm_on_s;
  logic [3:0]        nibble_s;
  logic [3:0]        anode_sel_s;
  logic [6:0]        digit_seg_s;
  logic              digit_dp_s;

  // Slot boundary detection and selection of the digit currently being scanned.
  always_comb begin
    slot_wrap_s = (slot_cnt_r == SLOT_LAST);
    frame_end_s = slot_wrap_s && (digit_r == 2'd3);
    if (slot_wrap_s) begin
      next_slot_s = '0;
    end else begin
      next_slot_s = slot_cnt_r + SLOT_W'(1);
    end
    pwm_on_s   = (pwm_cnt_r <= brightness);
    digit_dp_s = active_dp_r[digit_r];
    case (digit_r)
      2'd0: begin
        nibble_s    = active_data_r[3:0];
        anode_sel_s = 4'b1110;
      end
      2'd1: begin
        nibble_s    = active_data_r[7:4];
        anode_sel_s = 4'b1101;
      end
      2'd2: begin
        nibble_s    = active_data_r[11:8];
        anode_sel_s = 4'b1011;
      end
      default: begin
        nibble_s    = active_data_r[15:12];
        anode_sel_s = 4'b0111;
      end
    endcase
`ifdef SEG7_LZ_BLANK_EN
    if (lz_blank(active_data_r, digit_r)) begin
      digit_seg_s = 7'h7F;
    end else begin
      digit_seg_s = hex_to_seg(nibble_s);
    end
`else
    digit_seg_s = hex_to_seg(nibble_s);
`endif
  end

  // Slot counter, digit sequencer and blank/on FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
      digit_r    <= 2'd0;
      state_r    <= ST_BLANK;
    end else begin
      slot_cnt_r <= next_slot_s;
      if (slot_wrap_s) begin
        digit_r <= digit_r + 2'd1;
      end else begin
        digit_r <= digit_r;
      end
      case (state_r)
        ST_BLANK: state_r <= (next_slot_s == SLOT_ON) ? ST_ON : ST_BLANK;
        ST_ON:    state_r <= slot_wrap_s ? ST_BLANK : ST_ON;
        default:  state_r <= ST_BLANK;
      endcase
    end
  end

  // Free-running PWM phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 4'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 4'd1;
    end
  end

  // Shadow register: pending transfers to active only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_data_r <= 16'h0000;
      active_dp_r   <= 4'h0;
      pend_data_r   <= 16'h0000;
      pend_dp_r     <= 4'h0;
      pending_r     <= 1'b0;
    end else begin
      if (frame_end_s && pending_r) begin
        active_data_r <= pend_data_r;
        active_dp_r   <= pend_dp_r;
      end else begin
        active_data_r <= active_data_r;
        active_dp_r   <= active_dp_r;
      end
      if (load) begin
        pend_data_r <= data_in;
        pend_dp_r   <= dp_in;
        pending_r   <= 1'b1;
      end else if (frame_end_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Registered display pins; segments are forced off during blanking so lines settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_r      <= 4'hF;
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      if (state_r == ST_ON) begin
        anode_r <= pwm_on_s ? anode_sel_s : 4'hF;
        seg_r   <= digit_seg_s;
        dp_r    <= ~digit_dp_s;
      end else begin
        anode_r <= 4'hF;
        seg_r   <= 7'h7F;
        dp_r    <= 1'b1;
      end
    end
  end

  assign anode      = anode_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign pending    = pending_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller: arithmetic scan model compared every cycle,
// plus directed literal checks. Honours SEG7_LZ_BLANK_EN when defined.
`timescale 1ns/1ps
module tb_seg7_scan_controller;
  localparam int R  = 16;
  localparam int B  = 2;
  localparam int R2 = 20;

  logic        clk = 1'b0;
  logic        rst_n, load;
  logic [15:0] data_in;
  logic [3:0]  dp_in, brightness;
  logic [3:0]  anode, anode2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, pending, pending2, frame_done, frame_done2;

  int checks = 0;
  int fails  = 0;
  int cyc;

  logic [6:0] seg_ref [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .brightness(brightness), .anode(anode), .seg(seg), .dp(dp),
    .pending(pending), .frame_done(frame_done));

  seg7_scan_controller #(.REFRESH_DIV(R2), .BLANK_CYCLES(B)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .brightness(brightness), .anode(anode2), .seg(seg2), .dp(dp2),
    .pending(pending2), .frame_done(frame_done2));

  always #5 clk = ~clk;

  // Cycles since reset release; at a falling edge the pins reflect scan time cyc-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] disp(input logic [15:0] v, input int d);
    logic [15:0] upper;
    upper = v >> (4 * d);
`ifdef SEG7_LZ_BLANK_EN
    if (d > 0 && upper == 16'h0000) return 7'h7F;
`endif
    return seg_ref[upper[3:0]];
  endfunction

  // Behavioural model: scan position follows from elapsed time, shadow data from frame boundaries.
  int          t_m;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pending;

  always @(posedge clk) begin
    logic [3:0] e_anode;
    logic [6:0] e_seg;
    logic       e_dp, e_fd, on_s;
    int         slot, dig;
    if (!rst_n) begin
      t_m = 0; m_act = 16'h0; m_pend = 16'h0; m_act_dp = 4'h0; m_pend_dp = 4'h0; m_pending = 1'b0;
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      slot = t_m % R;
      dig  = (t_m / R) % 4;
      on_s = (slot >= B);
      e_anode = (on_s && (4'(t_m % 16) <= brightness)) ? (4'hF ^ (4'b0001 << dig)) : 4'hF;
      e_seg   = on_s ? disp(m_act, dig) : 7'h7F;
      e_dp    = on_s ? ~m_act_dp[dig] : 1'b1;
      e_fd    = (slot == R - 1) && (dig == 3);
      if (e_fd && m_pending) begin
        m_act = m_pend; m_act_dp = m_pend_dp;
      end
      if (load) begin
        m_pend = data_in; m_pend_dp = dp_in; m_pending = 1'b1;
      end else if (e_fd) begin
        m_pending = 1'b0;
      end
      t_m++;
    end
    #1;
    check("model_anode", anode, e_anode);
    check("model_seg", seg, e_seg);
    check("model_dp", dp, e_dp);
    check("model_frame_done", frame_done, e_fd);
    check("model_pending", pending, m_pending);
  end

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    check("frame_done_wait", frame_done, 1'b1);
  endtask

  task automatic capture_frame();
    for (int d = 0; d < 4; d++) begin
      cap_seg[d] = 7'h55; cap_dp[d] = 1'bx;
    end
    for (int k = 0; k < 4 * R; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (anode == (4'hF ^ (4'b0001 << d))) begin
          cap_seg[d] = seg; cap_dp[d] = dp;
        end
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    check({tag, "_d0"}, cap_seg[0], e0);
    check({tag, "_d1"}, cap_seg[1], e1);
    check({tag, "_d2"}, cap_seg[2], e2);
    check({tag, "_d3"}, cap_seg[3], e3);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int low_cnt [4];
  int blank_cnt, first_low, fd_cnt, fd_at, n, s, lows;

  initial begin
    rst_n = 1'b0; load = 1'b0; data_in = 16'h0; dp_in = 4'h0; brightness = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;

    // First frame after release: scan order, dead time, first-low latency, frame pulse.
    for (int d = 0; d < 4; d++) low_cnt[d] = 0;
    blank_cnt = 0; first_low = -1; fd_cnt = 0; fd_at = -1;
    for (int k = 1; k <= 4 * R; k++) begin
      @(negedge clk);
      case (anode)
        4'b1110: low_cnt[0]++;
        4'b1101: low_cnt[1]++;
        4'b1011: low_cnt[2]++;
        4'b0111: low_cnt[3]++;
        4'b1111: blank_cnt++;
        default: blank_cnt += 1000;
      endcase
      if (first_low < 0 && anode != 4'hF) first_low = k;
      if (frame_done) begin fd_cnt++; fd_at = k; end
    end
    for (int d = 0; d < 4; d++) check("low_cycles_per_digit", low_cnt[d], R - B);
    check("blank_cycles", blank_cnt, 4 * B);
    check("first_low_latency", first_low, B + 1);
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_at", fd_at, 64);
    wait_fd(n);
    check("frame_period", n, 64);

    // Load 1A8F and verify it appears only after the boundary.
    data_in = 16'h1A8F; dp_in = 4'b0101; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pending_after_load", pending, 1'b1);
    wait_fd(n);
    check("pending_cleared", pending, 1'b0);
    capture_frame();
    check_digits("hex1A8F", 7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001);
    check("dp_d0", cap_dp[0], 1'b0);
    check("dp_d1", cap_dp[1], 1'b1);

    // Load colliding with the boundary transfer.
    data_in = 16'h1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (cyc % 64 != 63) @(negedge clk);
    data_in = 16'h5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("collide_frame_done", frame_done, 1'b1);
    check("collide_pending_held", pending, 1'b1);
    capture_frame();
    check_digits("hex1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    check("collide_pending_cleared", pending, 1'b0);
    capture_frame();
    check_digits("hex5678", 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010);

    // Brightness duty over 16 consecutive ON cycles of the 20-cycle-slot instance.
    s = cyc / R2 + 1;
    wait_until(R2 * s + 2);
    brightness = 4'd0; lows = 0;
    repeat (16) begin @(negedge clk); if (anode2 != 4'hF) lows++; end
    check("duty_b0", lows, 1);
    wait_until(R2 * (s + 1) + 2);
    brightness = 4'd7; lows = 0;
    repeat (16) begin @(negedge clk); if (anode2 != 4'hF) lows++; end
    check("duty_b7", lows, 8);
    brightness = 4'hF;

    // Leading-zero pattern.
    data_in = 16'h0050; dp_in = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd(n);
    capture_frame();
`ifdef SEG7_LZ_BLANK_EN
    check_digits("hex0050", 7'b1000000, 7'b0010010, 7'h7F, 7'h7F);
`else
    check_digits("hex0050", 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000);
`endif

    // Asynchronous reset in the middle of the digit-2 slot.
    while (cyc % 64 != 40) @(negedge clk);
    check("pre_reset_digit2", anode, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_anode", anode, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    check("async_rst_pending", pending, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_blank1", anode, 4'hF);
    @(negedge clk);
    check("restart_blank2", anode, 4'hF);
    @(negedge clk);
    check("restart_digit0", anode, 4'b1110);
    check("restart_seg_zero", seg, 7'b1000000);
    repeat (70) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexing scan controller for the board's 4-digit common-anode seven-segment display. It replaces the free-running anode refresh with a digit scheduler that has four properties: a programmable slot period, dead-time blanking between digits to suppress ghosting, PWM brightness, and a tear-free shadow register for displayed data. It sits between the application logic, which supplies a 16-bit hex value, and the display pins (anodes, segments, decimal point).

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Legal range is greater than `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  one-cycle strobe that captures `data_in`/`dp_in` into the pending register.
- `data_in`  in  16  four hex nibbles. `[3:0]` is digit 0 (rightmost).
- `dp_in`  in  4  decimal-point enables, 1 = lit. Bit i maps to digit i.
- `brightness`  in  4  PWM level. 0 is the dimmest (1/16 duty); 15 is full on.
- `anode`  out  4  active-low digit enables. Bit i drives digit i.
- `seg`  out  7  active-low segments in the order {g,f,e,d,c,b,a}.
- `dp`  out  1  active-low decimal point.
- `pending`  out  1  high while a loaded value is waiting for the frame boundary.
- `frame_done`  out  1  one-cycle pulse when the digit-3 slot ends.

## Operation
- **Slot counter:** `slot_cnt` counts 0..`REFRESH_DIV`-1, then wraps.
  - On wrap, `digit` advances 0→1→2→3→0.
  - Digit 3 wrapping back to 0 is the frame boundary.
- **FSM states:**
  - `BLANK`: `slot_cnt` < `BLANK_CYCLES`. `anode`=4'b1111, `seg`=7'h7F, `dp`=1. `seg`/`dp` are also forced off so segment lines settle before the next anode enables.
  - `ON`: remainder of the slot. The FSM enters `ON` when `slot_cnt`==`BLANK_CYCLES` and returns to `BLANK` at slot wrap.
- **PWM:** a free-running 4-bit `pwm_cnt` increments every cycle.
  - In `ON`, the anode for `digit` is driven low only when `pwm_cnt` <= `brightness`. Otherwise all anodes are high.
  - `seg`/`dp` are driven from the current digit for the whole of `ON`.
  - `brightness` is sampled every cycle; changes take effect immediately.
- **Decode:** standard hex to seven-segment, active-low. Reference codes:
  - 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
- **Shadow register:**
  - `load` copies inputs into pending and sets `pending`.
  - At the frame boundary, if `pending` is set, pending is copied to active and `pending` clears.
  - `load` in the same cycle as the boundary transfer: the new value goes to pending, `pending` remains 1, and the previous pending value is transferred to active.
  - Repeated `load`s before a boundary: the last one wins.
- **Reset (`rst_n` low, any time, including mid-slot):**
  - `anode`=4'b1111, `seg`=7'h7F, `dp`=1, `pending`=0, `frame_done`=0.
  - Active and pending registers are 0; `digit`=0, `slot_cnt`=0, `pwm_cnt`=0, FSM in `BLANK`.
  - After release, scanning restarts with a digit-0 blank period.

## Timing
- All outputs are registered, with one cycle of latency from internal state to pins.
- The first anode low occurs `BLANK_CYCLES`+1 cycles after reset release, subject to the PWM condition.
- `frame_done` asserts in the cycle after the digit-3 slot wraps. It coincides with the active-register update becoming visible.
- A `load` reaches the display within at most 4×`REFRESH_DIV`+1 cycles.
- At most one anode is ever low, and no anode is low in the `BLANK` cycles at each slot boundary.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digits 3, 2 and 1 display blank (`seg`=7'h7F) when they and every higher digit are 0.
  - Digit 0 is never suppressed.
  - A digit's `dp` still lights if its `dp_in` bit is set.
- Undefined: all four digits always display their hex value.

## Test plan
- Reset release with `REFRESH_DIV`=16, `BLANK_CYCLES`=2, `brightness`=15, data 0 → `anode` sequence 1110/1101/1011/0111, each low for 14 cycles. Anodes are 1111 for 2 cycles between digits. `frame_done` pulses every 64 cycles.
- `load` with data 16'h1A8F → after the next boundary, `seg` shows 0001110, 0000000, 0001000, 1111001 for digits 0–3. `pending` is high from the cycle after `load` until the boundary.
- `brightness`=0 → the digit anode is low exactly 1 of every 16 `ON` cycles. `brightness`=7 → low 8 of every 16.
- `load` asserted in the frame-boundary cycle, with an earlier pending value 16'h1234 and new value 16'h5678 → 1234 is displayed for the next frame. `pending` stays 1, and 5678 is displayed one frame later.
- `rst_n` pulsed low mid-slot on digit 2 → outputs go to reset values immediately (asynchronous). Scanning restarts at digit 0 with blanking.
- With `SEG7_LZ_BLANK_EN` and data 16'h0050 → digits 3 and 2 are blank, and digits 1 and 0 show 5 and 0.
